// File: rtl/dx_latch_pkg.sv
// Shared constants for the decode-to-execute pipeline latch: opcode/rd field
// positions, the load-word opcode and the nop encoding.
package dx_latch_pkg;

    localparam logic [4:0]  OP_LW = 5'b01000;
    localparam logic [31:0] NOP   = 32'h0;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 27;
    localparam int RD_HI  = 26;
    localparam int RD_LO  = 22;

    function automatic logic [4:0] opcode_of(input logic [31:0] instr);
        return instr[OPC_HI:OPC_LO];
    endfunction

    function automatic logic [4:0] rd_of(input logic [31:0] instr);
        return instr[RD_HI:RD_LO];
    endfunction

endpackage

// File: rtl/dx_latch_pipe_reg.sv
// Generic pipeline register: async reset to zero, load enable, and a
// synchronous clear (to CLR_VAL) that only takes effect while enabled.
module pipe_reg #(
    parameter int             W       = 32,
    parameter logic [W-1:0]   CLR_VAL = '0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            if (clr) begin
                q <= CLR_VAL;
            end else begin
                q <= d;
            end
        end
    end

endmodule

// File: rtl/dx_latch.sv
// D/X pipeline latch with flush, hold and optional load-use bubble insertion.
// Load-use detection and the bubble counter exist only with DX_LOAD_USE_STALL_EN.
module dx_latch
    import dx_latch_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] d_pc,
    input  logic [31:0] d_instr,
    input  logic [31:0] d_regA,
    input  logic [31:0] d_regB,
    input  logic        d_valid,
    input  logic [4:0]  d_readregA,
    input  logic [4:0]  d_readregB,
    input  logic        x_ready,
    input  logic        flush,
    output logic [31:0] x_pc,
    output logic [31:0] x_instr,
    output logic [31:0] x_A,
    output logic [31:0] x_B,
    output logic        x_valid,
    output logic        d_stall,
    output logic [7:0]  bubble_count
);

    logic hazard;
    logic reg_en;
    logic reg_clr;

`ifdef DX_LOAD_USE_STALL_EN
    logic [4:0] x_rd;
    logic [7:0] bubble_q;

    assign x_rd   = rd_of(x_instr);
    assign hazard = x_valid && (opcode_of(x_instr) == OP_LW) && (x_rd != 5'd0) &&
                    d_valid && ((x_rd == d_readregA) || (x_rd == d_readregB));

    // Counts only bubbles actually inserted: a flush or a hold suppresses them.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bubble_q <= 8'h00;
        end else if (!flush && x_ready && hazard && (bubble_q != 8'hFF)) begin
            bubble_q <= bubble_q + 8'h01;
        end
    end

    assign bubble_count = bubble_q;
`else
    logic unused_readreg;

    assign hazard         = 1'b0;
    assign bubble_count   = 8'h00;
    assign unused_readreg = ^{d_readregA, d_readregB};
`endif

    assign reg_en  = x_ready | flush;
    assign reg_clr = flush | hazard;
    assign d_stall = ~flush & (~x_ready | hazard);

    pipe_reg #(.W(32)) u_pc (
        .clock(clock), .reset(reset), .en(reg_en), .clr(reg_clr), .d(d_pc), .q(x_pc)
    );

    pipe_reg #(.W(32), .CLR_VAL(NOP)) u_instr (
        .clock(clock), .reset(reset), .en(reg_en), .clr(reg_clr), .d(d_instr), .q(x_instr)
    );

    pipe_reg #(.W(32)) u_a (
        .clock(clock), .reset(reset), .en(reg_en), .clr(reg_clr), .d(d_regA), .q(x_A)
    );

    pipe_reg #(.W(32)) u_b (
        .clock(clock), .reset(reset), .en(reg_en), .clr(reg_clr), .d(d_regB), .q(x_B)
    );

    pipe_reg #(.W(1)) u_valid (
        .clock(clock), .reset(reset), .en(reg_en), .clr(reg_clr), .d(d_valid), .q(x_valid)
    );

endmodule

// File: tb/tb_dx_latch.sv
// Directed bench for dx_latch: a vector table plus hand sequences for the
// load-use, flush, hold, saturation and async-reset corners.
module tb_dx_latch;

`ifdef DX_LOAD_USE_STALL_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    typedef struct {
        logic        fl;
        logic        rdy;
        logic        v;
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic        e_stall;
        logic [31:0] e_pc;
        logic [31:0] e_ins;
        logic [31:0] e_a;
        logic [31:0] e_b;
        logic        e_v;
    } vec_t;

    logic        clock;
    logic        reset;
    logic [31:0] d_pc, d_instr, d_regA, d_regB;
    logic        d_valid;
    logic [4:0]  d_readregA, d_readregB;
    logic        x_ready, flush;
    logic [31:0] x_pc, x_instr, x_A, x_B;
    logic        x_valid, d_stall;
    logic [7:0]  bubble_count;

    int n_vec = 0;
    int n_err = 0;

    dx_latch dut (
        .clock(clock), .reset(reset),
        .d_pc(d_pc), .d_instr(d_instr), .d_regA(d_regA), .d_regB(d_regB),
        .d_valid(d_valid), .d_readregA(d_readregA), .d_readregB(d_readregB),
        .x_ready(x_ready), .flush(flush),
        .x_pc(x_pc), .x_instr(x_instr), .x_A(x_A), .x_B(x_B),
        .x_valid(x_valid), .d_stall(d_stall), .bubble_count(bubble_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        flush = t.fl; x_ready = t.rdy; d_valid = t.v;
        d_pc = t.pc; d_instr = t.ins; d_regA = t.a; d_regB = t.b;
        d_readregA = t.ra; d_readregB = t.rb;
    endtask

    task automatic chk_out(input string nm, input vec_t t, input logic [7:0] ebc);
        chk({nm, ".x_pc"},    x_pc,                 t.e_pc);
        chk({nm, ".x_instr"}, x_instr,              t.e_ins);
        chk({nm, ".x_A"},     x_A,                  t.e_a);
        chk({nm, ".x_B"},     x_B,                  t.e_b);
        chk({nm, ".x_valid"}, {31'd0, x_valid},     {31'd0, t.e_v});
        chk({nm, ".bubble"},  {24'd0, bubble_count}, {24'd0, ebc});
    endtask

    // Drive at the falling edge, check d_stall before the rising edge, then the latch after it.
    task automatic run(input string nm, input vec_t t, input logic [7:0] ebc);
        @(negedge clock);
        drive(t);
        #1;
        n_vec++;
        chk({nm, ".d_stall"}, {31'd0, d_stall}, {31'd0, t.e_stall});
        @(posedge clock);
        #1;
        chk_out(nm, t, ebc);
    endtask

    vec_t tbl [12];
    vec_t t;
    logic [7:0] b1;

    initial begin
        reset = 1'b1;
        drive('{1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0,
                1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0});

        //           fl    rdy   v     pc      instr          A      B      ra    rb     stall  x_pc    x_instr        x_A    x_B    x_v
        tbl[0]  = '{1'b0, 1'b1, 1'b1, 32'h40, 32'h08A40005, 32'h11, 32'h22, 5'd5, 5'd4, 1'b0, 32'h40, 32'h08A40005, 32'h11, 32'h22, 1'b1};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 32'h44, 32'h0C850007, 32'h33, 32'h44, 5'd1, 5'd2, 1'b0, 32'h44, 32'h0C850007, 32'h33, 32'h44, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 32'h48, 32'hAAAA0001, 32'h55, 32'h66, 5'd3, 5'd4, 1'b1, 32'h44, 32'h0C850007, 32'h33, 32'h44, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 32'h4C, 32'hBBBB0002, 32'h77, 32'h88, 5'd6, 5'd7, 1'b1, 32'h44, 32'h0C850007, 32'h33, 32'h44, 1'b1};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 32'h50, 32'hCCCC0003, 32'h99, 32'hAA, 5'd8, 5'd9, 1'b1, 32'h44, 32'h0C850007, 32'h33, 32'h44, 1'b1};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 32'h54, 32'hDDDD0004, 32'h01, 32'h02, 5'd0, 5'd0, 1'b0, 32'h00, 32'h00000000, 32'h00, 32'h00, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 32'h58, 32'h12345678, 32'h0C, 32'h0D, 5'd1, 5'd1, 1'b0, 32'h58, 32'h12345678, 32'h0C, 32'h0D, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 32'h5C, 32'h40010004, 32'h55, 32'h66, 5'd0, 5'd0, 1'b0, 32'h5C, 32'h40010004, 32'h55, 32'h66, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 32'h60, 32'h08A40005, 32'h77, 32'h88, 5'd0, 5'd0, 1'b0, 32'h60, 32'h08A40005, 32'h77, 32'h88, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 32'h64, 32'h40C00000, 32'h01, 32'h02, 5'd0, 5'd0, 1'b0, 32'h64, 32'h40C00000, 32'h01, 32'h02, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 32'h68, 32'h08A40005, 32'h03, 32'h04, 5'd3, 5'd3, 1'b0, 32'h68, 32'h08A40005, 32'h03, 32'h04, 1'b1};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 32'h6C, 32'h11111111, 32'h05, 32'h06, 5'd0, 5'd0, 1'b0, 32'h00, 32'h00000000, 32'h00, 32'h00, 1'b0};

        #12;
        n_vec++;
        chk("reset.d_stall", {31'd0, d_stall}, 32'd0);
        chk_out("reset", tbl[5], 8'h00);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run($sformatf("tbl%0d", i), tbl[i], 8'h00);
        end

        // Load-use on port A: one bubble, then the held instruction is captured.
        run("lu_cap", '{1'b0, 1'b1, 1'b1, 32'h100, 32'h40C00000, 32'h1, 32'h2, 5'd0, 5'd0,
                        1'b0, 32'h100, 32'h40C00000, 32'h1, 32'h2, 1'b1}, 8'h00);
        t = EN ? '{1'b0, 1'b1, 1'b1, 32'h104, 32'h08A40005, 32'h5, 32'h6, 5'd3, 5'd7,
                   1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0}
               : '{1'b0, 1'b1, 1'b1, 32'h104, 32'h08A40005, 32'h5, 32'h6, 5'd3, 5'd7,
                   1'b0, 32'h104, 32'h08A40005, 32'h5, 32'h6, 1'b1};
        b1 = EN ? 8'h01 : 8'h00;
        run("lu_bubble", t, b1);
        run("lu_resume", '{1'b0, 1'b1, 1'b1, 32'h104, 32'h08A40005, 32'h5, 32'h6, 5'd3, 5'd7,
                           1'b0, 32'h104, 32'h08A40005, 32'h5, 32'h6, 1'b1}, b1);

        // Flush beats the hazard: nop, no count.
        run("fh_cap", '{1'b0, 1'b1, 1'b1, 32'h108, 32'h40C00000, 32'h7, 32'h8, 5'd0, 5'd0,
                        1'b0, 32'h108, 32'h40C00000, 32'h7, 32'h8, 1'b1}, b1);
        run("fh_flush", '{1'b1, 1'b1, 1'b1, 32'h10C, 32'h08A40005, 32'h9, 32'h9, 5'd3, 5'd0,
                          1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0}, b1);

        // Hazard on port B while X is busy: hold wins, bubble follows once ready.
        run("hb_cap", '{1'b0, 1'b1, 1'b1, 32'h110, 32'h40C00000, 32'h9, 32'hA, 5'd0, 5'd0,
                        1'b0, 32'h110, 32'h40C00000, 32'h9, 32'hA, 1'b1}, b1);
        run("hb_hold", '{1'b0, 1'b0, 1'b1, 32'h114, 32'h08A40005, 32'hB, 32'hC, 5'd0, 5'd3,
                         1'b1, 32'h110, 32'h40C00000, 32'h9, 32'hA, 1'b1}, b1);
        t = EN ? '{1'b0, 1'b1, 1'b1, 32'h114, 32'h08A40005, 32'hB, 32'hC, 5'd0, 5'd3,
                   1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0}
               : '{1'b0, 1'b1, 1'b1, 32'h114, 32'h08A40005, 32'hB, 32'hC, 5'd0, 5'd3,
                   1'b0, 32'h114, 32'h08A40005, 32'hB, 32'hC, 1'b1};
        run("hb_bubble", t, EN ? 8'h02 : 8'h00);

        // Back-to-back lw rd=5 with a use on port B: one bubble every two cycles.
        @(negedge clock);
        drive('{1'b0, 1'b1, 1'b1, 32'h200, 32'h41400000, 32'h0, 32'h0, 5'd0, 5'd5,
                1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0});
        repeat (600) @(posedge clock);
        #1;
        n_vec++;
        chk("sat.bubble", {24'd0, bubble_count}, EN ? 32'hFF : 32'h0);

        // Async reset in the middle of a load-use stall.
        run("rst_cap", '{1'b0, 1'b1, 1'b1, 32'h300, 32'h40C00000, 32'h1, 32'h2, 5'd0, 5'd0,
                         1'b0, 32'h300, 32'h40C00000, 32'h1, 32'h2, 1'b1}, EN ? 8'hFF : 8'h00);
        @(negedge clock);
        drive('{1'b0, 1'b1, 1'b1, 32'h304, 32'h08A40005, 32'h3, 32'h4, 5'd3, 5'd0,
                1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0});
        #1;
        n_vec++;
        chk("rst_pre.d_stall", {31'd0, d_stall}, {31'd0, EN});
        reset = 1'b1;
        #1;
        n_vec++;
        chk("rst_mid.d_stall", {31'd0, d_stall}, 32'd0);
        chk_out("rst_mid", tbl[5], 8'h00);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        n_vec++;
        chk_out("rst_after", '{1'b0, 1'b1, 1'b1, 32'h304, 32'h08A40005, 32'h3, 32'h4, 5'd3, 5'd0,
                               1'b0, 32'h304, 32'h08A40005, 32'h3, 32'h4, 1'b1}, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
